ringer_cadence: RTL and testbench

Runtime-programmable alarm tone generator and the parametrised successor to the fixed-frequency ringer. It produces a square-wave `sound` with a configurable half-period. The tone is gated by one of three cadences: continuous, pulsed (repeating on/off) or burst (N beeps, then done). It sits between the alarm-control logic, which drives `on`, `mode` and the timing words, and the buzzer output pin.

---
 rtl/ringer_cadence_if.sv | 26 ++
 rtl/ringer_cadence.sv | 149 ++++++++++++++
 tb/tb_ringer_cadence.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ringer_cadence_if.sv
// Control/status bundle between the alarm-control logic and the cadence generator.
// The master drives enable, mode and timing words; the slave returns buzzer drive and status.
interface ringer_cadence_if #(
    parameter int CNT_W  = 16,
    parameter int BEEP_W = 4
);
    logic              on;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  half_period;
    logic [CNT_W-1:0]  on_len;
    logic [CNT_W-1:0]  off_len;
    logic [BEEP_W-1:0] burst_len;
    logic              sound;
    logic              active;
    logic              done;

    modport master (
        output on, mode, half_period, on_len, off_len, burst_len,
        input  sound, active, done
    );

    modport slave (
        input  on, mode, half_period, on_len, off_len, burst_len,
        output sound, active, done
    );
endinterface

// File: rtl/ringer_cadence.sv
// Purpose: square-wave alarm tone gated by continuous, pulsed or burst cadence.
// Latency: on sampled high -> sound/active high after the same edge; on low -> silent one edge later.
// Backpressure: none; level-controlled, configuration frozen from IDLE exit until IDLE re-entry.
module ringer_cadence #(
    parameter int CNT_W  = 16,
    parameter int BEEP_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ringer_cadence_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_TONE = 2'b01;
    localparam logic [1:0] S_GAP  = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    localparam logic [1:0] MODE_CONT  = 2'b00;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
    localparam logic [BEEP_W-1:0] B_ONE = BEEP_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_hp;
    logic [CNT_W-1:0]  r_on_len;
    logic [CNT_W-1:0]  r_off_len;
    logic [BEEP_W-1:0] r_burst_len;
    logic [CNT_W-1:0]  r_tone_cnt;
    logic [CNT_W-1:0]  r_len_cnt;
    logic [CNT_W-1:0]  r_gap_cnt;
    logic [BEEP_W-1:0] r_beep_cnt;
    logic              r_sound;
    logic              r_done;

    logic [CNT_W-1:0]  w_hp_in;
    logic [CNT_W-1:0]  w_on_len_in;
    logic [CNT_W-1:0]  w_off_len_in;
    logic              w_tone_end;
    logic              w_len_end;
    logic              w_gap_end;
    logic              w_last_beep;

    // Zero timing words are promoted to 1 so every terminal compare below is reachable.
    assign w_hp_in      = (bus.half_period == '0) ? C_ONE : bus.half_period;
    assign w_on_len_in  = (bus.on_len      == '0) ? C_ONE : bus.on_len;
    assign w_off_len_in = (bus.off_len     == '0) ? C_ONE : bus.off_len;

    assign w_tone_end  = (r_tone_cnt == r_hp - C_ONE);
    assign w_len_end   = (r_len_cnt  == r_on_len - C_ONE);
    assign w_gap_end   = (r_gap_cnt  == r_off_len - C_ONE);
    assign w_last_beep = (r_beep_cnt == r_burst_len - B_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_CONT;
            r_hp        <= C_ONE;
            r_on_len    <= C_ONE;
            r_off_len   <= C_ONE;
            r_burst_len <= '0;
            r_tone_cnt  <= '0;
            r_len_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_beep_cnt  <= '0;
            r_sound     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!bus.on) begin
                r_state    <= S_IDLE;
                r_sound    <= 1'b0;
                r_tone_cnt <= '0;
                r_len_cnt  <= '0;
                r_gap_cnt  <= '0;
                r_beep_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.mode != MODE_RSVD) begin
                            r_mode      <= bus.mode;
                            r_hp        <= w_hp_in;
                            r_on_len    <= w_on_len_in;
                            r_off_len   <= w_off_len_in;
                            r_burst_len <= bus.burst_len;
                            r_tone_cnt  <= '0;
                            r_len_cnt   <= '0;
                            r_gap_cnt   <= '0;
                            r_beep_cnt  <= '0;
                            if (bus.mode == MODE_BURST && bus.burst_len == '0) begin
                                r_state <= S_HOLD;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_TONE;
                                r_sound <= 1'b1;
                            end
                        end
                    end
                    S_TONE: begin
                        if (w_tone_end) begin
                            r_tone_cnt <= '0;
                            r_sound    <= ~r_sound;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + C_ONE;
                        end
                        // Leaving TONE silences the output even if a toggle lands on this edge.
                        if (r_mode != MODE_CONT) begin
                            if (w_len_end) begin
                                r_len_cnt  <= '0;
                                r_tone_cnt <= '0;
                                r_sound    <= 1'b0;
                                if (r_mode == MODE_BURST && w_last_beep) begin
                                    r_state    <= S_HOLD;
                                    r_done     <= 1'b1;
                                    r_beep_cnt <= '0;
                                end else begin
                                    r_state <= S_GAP;
                                    if (r_mode == MODE_BURST)
                                        r_beep_cnt <= r_beep_cnt + B_ONE;
                                end
                            end else begin
                                r_len_cnt <= r_len_cnt + C_ONE;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_gap_end) begin
                            r_gap_cnt  <= '0;
                            r_state    <= S_TONE;
                            r_sound    <= 1'b1;
                            r_tone_cnt <= '0;
                            r_len_cnt  <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + C_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.sound  = r_sound;
    assign bus.active = (r_state == S_TONE);
    assign bus.done   = r_done;
endmodule

// File: tb/tb_ringer_cadence.sv
// Directed bench: each step pushes the per-cycle {sound,active,done} it expects, then drains the queue.
module tb_ringer_cadence;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [2:0] exp_q[$];

    ringer_cadence_if #(.CNT_W(16), .BEEP_W(4)) u_if ();

    ringer_cadence #(.CNT_W(16), .BEEP_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Strings of '0'/'1', one character per cycle, for sound/active/done.
    task automatic push_str(input string s, input string a, input string d);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back({s[i] == "1", a[i] == "1", d[i] == "1"});
    endtask

    task automatic push_rep(input string s, input string a, input string d, input int n);
        for (int k = 0; k < n; k++) push_str(s, a, d);
    endtask

    task automatic check_now(input string tag);
        logic [2:0] obs;
        logic [2:0] expv;
        expv = exp_q.pop_front();
        obs  = {u_if.sound, u_if.active, u_if.done};
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed sad=%b required sad=%b", tag, obs, expv);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            check_now(tag);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input int hp, input int onl, input int offl, input int bl);
        u_if.mode        = m;
        u_if.half_period = 16'(hp);
        u_if.on_len      = 16'(onl);
        u_if.off_len     = 16'(offl);
        u_if.burst_len   = 4'(bl);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        u_if.on = 1'b0;
        cfg(2'b00, 2, 1, 1, 0);
        #12;
        push_str("0", "0", "0");
        check_now("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Continuous tone, then an asynchronous reset mid-cycle.
        u_if.on = 1'b1;
        push_str("11001100", "11111111", "00000000");
        drain("cont_hp2");
        #3 rst_n = 1'b0;
        #1;
        push_str("0", "0", "0");
        check_now("async_reset");
        #1 rst_n = 1'b1;
        push_str("110011001", "111111111", "000000000");
        drain("cont_after_reset");
        u_if.on = 1'b0;
        push_str("000", "000", "000");
        drain("stop_latency");

        // Pulsed cadence.
        cfg(2'b01, 1, 4, 3, 0);
        u_if.on = 1'b1;
        push_rep("1010000", "1111000", "0000000", 2);
        drain("pulsed");
        u_if.on = 1'b0;
        push_str("00", "00", "00");
        drain("pulsed_stop");

        // Burst of three, then hold without retrigger.
        cfg(2'b10, 1, 2, 2, 3);
        u_if.on = 1'b1;
        push_str("1000100010", "1100110011", "0000000000");
        push_str("000000", "000000", "100000");
        drain("burst");
        u_if.on = 1'b0;
        push_str("00", "00", "00");
        drain("burst_release");

        // New burst, aborted during the second beep.
        u_if.on = 1'b1;
        push_str("10001", "11001", "00000");
        drain("burst_restart");
        u_if.on = 1'b0;
        push_str("00000", "00000", "00000");
        drain("abort_mid_beep");
        u_if.on = 1'b1;
        push_str("10", "11", "00");
        drain("abort_returns_idle");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("abort_stop");

        // Zero-length burst.
        cfg(2'b10, 1, 2, 2, 0);
        u_if.on = 1'b1;
        push_str("00000", "00000", "10000");
        drain("burst_len0");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("burst_len0_stop");

        // Zero half-period behaves as one.
        cfg(2'b00, 0, 1, 1, 0);
        u_if.on = 1'b1;
        push_str("101010", "111111", "000000");
        drain("hp0");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("hp0_stop");

        // Reserved mode stays silent.
        cfg(2'b11, 1, 1, 1, 1);
        u_if.on = 1'b1;
        push_str("00000", "00000", "00000");
        drain("mode11");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("mode11_stop");

        // Configuration freeze: hp change ignored until on is cycled.
        cfg(2'b01, 2, 10, 2, 0);
        u_if.on = 1'b1;
        push_str("11001", "11111", "00000");
        drain("freeze_pre");
        u_if.half_period = 16'd5;
        push_str("10011", "11111", "00000");
        push_str("00110011001100", "00111111111100", "00000000000000");
        drain("freeze_hold");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("freeze_cycle");
        u_if.on = 1'b1;
        push_rep("111110000000", "111111111100", "000000000000", 2);
        drain("freeze_new_hp");
        u_if.on = 1'b0;
        push_str("0", "0", "0");
        drain("freeze_stop");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
